// File: rtl/bf_pkg.sv
// Shared types for the bf* pipeline buffers: default widths, occupancy encoding
// and the buffered-entry layout.
package bf_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam int TW_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  typedef struct packed {
    logic [DW_DEF-1:0] result;
    logic [AW_DEF-1:0] rd;
    logic [TW_DEF-1:0] tag;
    logic              valid;
  } entry_t;

endpackage

// File: rtl/bf2_entry.sv
// One buffered result slot with load and clear. Instantiated as HEAD and SKID
// inside bf2_writeback.
module bf2_entry #(
  parameter type slot_t = bf_pkg::entry_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  clear,
  input  slot_t d,
  output slot_t q
);

  // NOTE: clear beats load, so a flushed slot never captures the entry arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) q <= '0;
    else if (load)    q <= d;
  end

endmodule

// File: rtl/bf2_writeback.sv
// EX->WB two-entry skid buffer issuing one register-file write per cycle.
// Optional retire counter enabled by defining BF2_RETIRE_CNT_EN.
module bf2_writeback
  import bf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic          clk_BF2,
  input  logic          rst_BF2,
  input  logic          validIn_BF2,
  output logic          readyOut_BF2,
  input  logic [DW-1:0] dIn1_BF2,
  input  logic [AW-1:0] dIn2_BF2,
  input  logic [TW-1:0] dIn3_BF2,
  input  logic          flush_BF2,
  input  logic          wbReady_BF2,
  output logic          wbEn_BF2,
  output logic [AW-1:0] wbAddr_BF2,
  output logic [DW-1:0] wbData_BF2,
  output logic [TW-1:0] wbTag_BF2,
  output logic          fwdValid_BF2,
  output logic [AW-1:0] fwdAddr_BF2,
  output logic [DW-1:0] fwdData_BF2
`ifdef BF2_RETIRE_CNT_EN
  ,
  output logic [31:0]   retireCnt_BF2
`endif
);

  typedef struct packed {
    logic [DW-1:0] result;
    logic [AW-1:0] rd;
    logic [TW-1:0] tag;
    logic          valid;
  } slot_t;

  occ_t  occ, occ_nxt;
  slot_t head, skid, in_slot, head_d;
  logic  head_load, head_clear, skid_load, skid_clear;
  logic  ready_q, accept, drain, head_wr;

  assign in_slot = '{result: dIn1_BF2, rd: dIn2_BF2, tag: dIn3_BF2, valid: 1'b1};
  assign accept  = validIn_BF2 & ready_q;
  assign head_wr = head.valid & (head.rd != '0);
  // rd = 0 entries retire without waiting for the write port.
  assign drain   = head.valid & (wbReady_BF2 | (head.rd == '0));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    occ_nxt    = occ;
    head_d     = in_slot;
    head_load  = 1'b0;
    head_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush_BF2) begin
      occ_nxt    = EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (occ)
        EMPTY: begin
          if (accept) begin
            head_load = 1'b1;
            occ_nxt   = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            head_load = 1'b1;
          end else if (accept) begin
            skid_load = 1'b1;
            occ_nxt   = TWO;
          end else if (drain) begin
            head_clear = 1'b1;
            occ_nxt    = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            head_d     = skid;
            head_load  = 1'b1;
            skid_clear = 1'b1;
            occ_nxt    = ONE;
          end
        end
        default: begin
          occ_nxt    = EMPTY;
          head_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_BF2) begin
    if (rst_BF2) begin
      occ     <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      occ     <= occ_nxt;
      ready_q <= (occ_nxt != TWO);
    end
  end

  bf2_entry #(.slot_t(slot_t)) u_head (
    .clk   (clk_BF2),
    .rst   (rst_BF2),
    .load  (head_load),
    .clear (head_clear),
    .d     (head_d),
    .q     (head)
  );

  bf2_entry #(.slot_t(slot_t)) u_skid (
    .clk   (clk_BF2),
    .rst   (rst_BF2),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_slot),
    .q     (skid)
  );

  // Slots are cleared whenever they go invalid, so the fields read 0 when empty.
  // A flushed head must not reach the register file in the flush cycle.
  assign readyOut_BF2 = ready_q;
  assign wbEn_BF2     = head_wr & ~flush_BF2;
  assign wbAddr_BF2   = head.rd;
  assign wbData_BF2   = head.result;
  assign wbTag_BF2    = head.tag;
  assign fwdValid_BF2 = head_wr;
  assign fwdAddr_BF2  = head.rd;
  assign fwdData_BF2  = head.result;

`ifdef BF2_RETIRE_CNT_EN
  logic [31:0] retire_cnt;

  always_ff @(posedge clk_BF2) begin
    if (rst_BF2)                  retire_cnt <= '0;
    else if (drain && !flush_BF2) retire_cnt <= retire_cnt + 32'd1;
  end

  assign retireCnt_BF2 = retire_cnt;
`endif

endmodule

// File: tb/tb_bf2_writeback.sv
// Directed self-checking bench for bf2_writeback; the retire-counter scenario
// is built only when BF2_RETIRE_CNT_EN is defined.
module tb_bf2_writeback;

  logic        clk_BF2 = 1'b0;
  logic        rst_BF2;
  logic        validIn_BF2;
  logic        readyOut_BF2;
  logic [31:0] dIn1_BF2;
  logic [4:0]  dIn2_BF2;
  logic [7:0]  dIn3_BF2;
  logic        flush_BF2;
  logic        wbReady_BF2;
  logic        wbEn_BF2;
  logic [4:0]  wbAddr_BF2;
  logic [31:0] wbData_BF2;
  logic [7:0]  wbTag_BF2;
  logic        fwdValid_BF2;
  logic [4:0]  fwdAddr_BF2;
  logic [31:0] fwdData_BF2;
`ifdef BF2_RETIRE_CNT_EN
  logic [31:0] retireCnt_BF2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_BF2 = ~clk_BF2;

  bf2_writeback dut (
    .clk_BF2      (clk_BF2),
    .rst_BF2      (rst_BF2),
    .validIn_BF2  (validIn_BF2),
    .readyOut_BF2 (readyOut_BF2),
    .dIn1_BF2     (dIn1_BF2),
    .dIn2_BF2     (dIn2_BF2),
    .dIn3_BF2     (dIn3_BF2),
    .flush_BF2    (flush_BF2),
    .wbReady_BF2  (wbReady_BF2),
    .wbEn_BF2     (wbEn_BF2),
    .wbAddr_BF2   (wbAddr_BF2),
    .wbData_BF2   (wbData_BF2),
    .wbTag_BF2    (wbTag_BF2),
    .fwdValid_BF2 (fwdValid_BF2),
    .fwdAddr_BF2  (fwdAddr_BF2),
    .fwdData_BF2  (fwdData_BF2)
`ifdef BF2_RETIRE_CNT_EN
    ,
    .retireCnt_BF2(retireCnt_BF2)
`endif
  );

  // Advance past the next rising edge; outputs are then stable for sampling.
  task automatic step();
    @(posedge clk_BF2);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] rd, input logic [7:0] tag);
    validIn_BF2 = v;
    dIn1_BF2    = d;
    dIn2_BF2    = rd;
    dIn3_BF2    = tag;
  endtask

  task automatic expect_idle(input string name);
    checks++;
    if (wbEn_BF2 !== 1'b0 || fwdValid_BF2 !== 1'b0 || readyOut_BF2 !== 1'b1 ||
        wbAddr_BF2 !== 5'd0 || wbData_BF2 !== 32'd0 || wbTag_BF2 !== 8'd0 ||
        fwdAddr_BF2 !== 5'd0 || fwdData_BF2 !== 32'd0) begin
      errors++;
      $display("FAIL %s: got en=%b fv=%b rdy=%b addr=%h data=%h tag=%h faddr=%h fdata=%h, want en=0 fv=0 rdy=1 and zero fields",
               name, wbEn_BF2, fwdValid_BF2, readyOut_BF2, wbAddr_BF2, wbData_BF2, wbTag_BF2,
               fwdAddr_BF2, fwdData_BF2);
    end
  endtask

  task automatic expect_head(input string name, input logic en, input logic [4:0] addr,
                             input logic [31:0] data, input logic rdy);
    checks++;
    if (wbEn_BF2 !== en || wbAddr_BF2 !== addr || wbData_BF2 !== data ||
        readyOut_BF2 !== rdy || fwdValid_BF2 !== en || fwdAddr_BF2 !== addr ||
        fwdData_BF2 !== data) begin
      errors++;
      $display("FAIL %s: got en=%b addr=%0d data=%h rdy=%b fv=%b faddr=%0d fdata=%h, want en=%b addr=%0d data=%h rdy=%b",
               name, wbEn_BF2, wbAddr_BF2, wbData_BF2, readyOut_BF2, fwdValid_BF2,
               fwdAddr_BF2, fwdData_BF2, en, addr, data, rdy);
    end
  endtask

  task automatic test_reset();
    rst_BF2 = 1'b1;
    flush_BF2 = 1'b0;
    wbReady_BF2 = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 8'd0);
    step();
    step();
    rst_BF2 = 1'b0;
    expect_idle("reset_outputs");
  endtask

  task automatic test_basic_write();
    wbReady_BF2 = 1'b1;
    drive(1'b1, 32'h0000_00A5, 5'd3, 8'h11);
    step();
    drive(1'b0, 32'd0, 5'd0, 8'd0);
    expect_head("basic_write", 1'b1, 5'd3, 32'h0000_00A5, 1'b1);
    checks++;
    if (wbTag_BF2 !== 8'h11) begin
      errors++;
      $display("FAIL basic_tag: got %h want 11", wbTag_BF2);
    end
  endtask

  task automatic test_back_to_back();
    wbReady_BF2 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h1000 + 32'(i), 5'(4 + i), 8'(i));
      step();
      expect_head($sformatf("b2b_write_%0d", i), 1'b1, 5'(4 + i), 32'h1000 + 32'(i), 1'b1);
    end
    drive(1'b0, 32'd0, 5'd0, 8'd0);
    step();
    expect_idle("b2b_drained");
  endtask

  task automatic test_stall();
    wbReady_BF2 = 1'b0;
    drive(1'b1, 32'h100, 5'd1, 8'h01);
    step();
    expect_head("stall_one", 1'b1, 5'd1, 32'h100, 1'b1);
    drive(1'b1, 32'h200, 5'd2, 8'h02);
    step();
    expect_head("stall_two_not_ready", 1'b1, 5'd1, 32'h100, 1'b0);
    drive(1'b1, 32'h300, 5'd3, 8'h03);
    for (int k = 0; k < 3; k++) begin
      step();
      expect_head($sformatf("stall_hold_%0d", k), 1'b1, 5'd1, 32'h100, 1'b0);
    end
    drive(1'b0, 32'd0, 5'd0, 8'd0);
    wbReady_BF2 = 1'b1;
    step();
    expect_head("release_second", 1'b1, 5'd2, 32'h200, 1'b1);
    step();
    expect_idle("release_no_third");
  endtask

  task automatic test_rd_zero();
    wbReady_BF2 = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 5'd0, 8'h22);
    step();
    drive(1'b0, 32'd0, 5'd0, 8'd0);
    expect_head("rd0_no_write", 1'b0, 5'd0, 32'hDEAD_BEEF, 1'b1);
    step();
    expect_idle("rd0_retired");
  endtask

  task automatic test_flush();
`ifdef BF2_RETIRE_CNT_EN
    logic [31:0] cnt_before;
`endif
    wbReady_BF2 = 1'b0;
    drive(1'b1, 32'h500, 5'd5, 8'h05);
    step();
    drive(1'b1, 32'h600, 5'd6, 8'h06);
    step();
    drive(1'b0, 32'd0, 5'd0, 8'd0);
    expect_head("flush_pre_two", 1'b1, 5'd5, 32'h500, 1'b0);
`ifdef BF2_RETIRE_CNT_EN
    cnt_before = retireCnt_BF2;
`endif
    flush_BF2 = 1'b1;
    wbReady_BF2 = 1'b1;
    step();
    flush_BF2 = 1'b0;
    expect_idle("flush_empty");
    step();
    expect_idle("flush_skid_dropped");
`ifdef BF2_RETIRE_CNT_EN
    checks++;
    if (retireCnt_BF2 !== cnt_before) begin
      errors++;
      $display("FAIL flush_count: got %0d want %0d", retireCnt_BF2, cnt_before);
    end
`endif
  endtask

  task automatic test_reset_mid_fill();
    wbReady_BF2 = 1'b0;
    drive(1'b1, 32'h700, 5'd7, 8'h07);
    step();
    drive(1'b1, 32'h800, 5'd8, 8'h08);
    rst_BF2 = 1'b1;
    step();
    rst_BF2 = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 8'd0);
    expect_idle("rst_mid_fill");
`ifdef BF2_RETIRE_CNT_EN
    checks++;
    if (retireCnt_BF2 !== 32'd0) begin
      errors++;
      $display("FAIL rst_count: got %0d want 0", retireCnt_BF2);
    end
`endif
    wbReady_BF2 = 1'b1;
    step();
    expect_idle("rst_nothing_left");
  endtask

`ifdef BF2_RETIRE_CNT_EN
  task automatic test_retire_count();
    rst_BF2 = 1'b1;
    step();
    rst_BF2 = 1'b0;
    wbReady_BF2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i), (i == 2) ? 5'd0 : 5'(i + 1), 8'(i));
      step();
    end
    drive(1'b0, 32'd0, 5'd0, 8'd0);
    step();
    checks++;
    if (retireCnt_BF2 !== 32'd5) begin
      errors++;
      $display("FAIL count_five: got %0d want 5", retireCnt_BF2);
    end
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    drive(1'b1, 32'h900, 5'd9, 8'h09);
    step();
    drive(1'b0, 32'd0, 5'd0, 8'd0);
    checks++;
    if (retireCnt_BF2 !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL count_preload: got %h want ffffffff", retireCnt_BF2);
    end
    step();
    checks++;
    if (retireCnt_BF2 !== 32'd0) begin
      errors++;
      $display("FAIL count_wrap: got %h want 0", retireCnt_BF2);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_stall();
    test_rd_zero();
    test_flush();
    test_reset_mid_fill();
`ifdef BF2_RETIRE_CNT_EN
    test_retire_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
